// File: rtl/mod_n_event_counter.sv
// Up/down event counter modulo N with load, wrap pulse
// and a saturating count of wraps.
module mod_n_event_counter #(
  parameter int MOD    = 10,
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic              dir,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              wrap_clr,
  output logic [WIDTH-1:0]  count,
  output logic              out,
  output logic              wrap,
  output logic [WRAP_W-1:0] wraps,
  output logic              load_err
);

  // Compares run in a width that can hold the modulus itself,
  // so a power-of-two modulus needs no overflow trick.
  localparam int XW = (WIDTH > 16) ? WIDTH + 1 : 17;
  localparam logic [XW-1:0] MOD_X  = XW'(MOD);
  localparam logic [XW-1:0] LAST_X = XW'(MOD - 1);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  logic [XW-1:0] cnt_x;
  logic [XW-1:0] lv_x;
  logic          at_top;
  logic          at_bot;
  logic          bad;
  logic          lv_ok;
  logic          step_wrap;

  assign cnt_x  = XW'(count);
  assign lv_x   = XW'(load_val);
  assign at_top = (cnt_x == LAST_X);
  assign at_bot = (count == '0);
  assign bad    = (cnt_x >= MOD_X);
  assign lv_ok  = (lv_x < MOD_X);

  // A step that crosses the modulus boundary this cycle.
  assign step_wrap = !load && !bad && in &&
                     (dir ? at_top : at_bot);

  // Terminal count follows the current direction immediately.
  assign out = dir ? at_top : at_bot;

  // Count register: reset, then load, then recovery, then step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (lv_ok) begin
          count <= load_val;
        end else begin
          count    <= '0;
          load_err <= 1'b1;
        end
      end else if (bad) begin
        count <= '0;
      end else if (in) begin
        if (dir) begin
          if (at_top) begin
            count <= '0;
            wrap  <= 1'b1;
          end else begin
            count <= count + WIDTH'(1);
          end
        end else begin
          if (at_bot) begin
            count <= LAST;
            wrap  <= 1'b1;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
      end
    end
  end

  // Saturating wrap total; a wrap beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wraps <= '0;
    end else if (step_wrap) begin
      if (wrap_clr) begin
        wraps <= WRAP_W'(1);
      end else if (wraps != '1) begin
        wraps <= wraps + WRAP_W'(1);
      end
    end else if (wrap_clr) begin
      wraps <= '0;
    end
  end

endmodule

// File: tb/tb_mod_n_event_counter.sv
// Directed table plus hand sequences for the
// modulo-N event counter, several parameter sets.
module tb_mod_n_event_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       in = 1'b0;
  logic       dir = 1'b1;
  logic       load = 1'b0;
  logic       wclr = 1'b0;
  logic [3:0] lva = '0;
  logic [3:0] lv16 = '0;
  logic [2:0] lv7 = '0;

  logic [3:0] ca, cb, c16;
  logic [2:0] c7;
  logic       oa, ob, o16, o7;
  logic       wa, wb, w16, w7;
  logic [7:0] wsa, ws16, ws7;
  logic [1:0] wsb;
  logic       ea, eb, e16, e7;

  mod_n_event_counter dut_a (
    .clk(clk), .rst(rst), .in(in), .dir(dir),
    .load(load), .load_val(lva), .wrap_clr(wclr),
    .count(ca), .out(oa), .wrap(wa), .wraps(wsa),
    .load_err(ea)
  );

  mod_n_event_counter #(.WRAP_W(2)) dut_b (
    .clk(clk), .rst(rst), .in(in), .dir(dir),
    .load(load), .load_val(lva), .wrap_clr(wclr),
    .count(cb), .out(ob), .wrap(wb), .wraps(wsb),
    .load_err(eb)
  );

  mod_n_event_counter #(.MOD(16), .WIDTH(4)) dut_16 (
    .clk(clk), .rst(rst), .in(in), .dir(dir),
    .load(load), .load_val(lv16), .wrap_clr(wclr),
    .count(c16), .out(o16), .wrap(w16), .wraps(ws16),
    .load_err(e16)
  );

  mod_n_event_counter #(.MOD(7), .WIDTH(3)) dut_7 (
    .clk(clk), .rst(rst), .in(in), .dir(dir),
    .load(load), .load_val(lv7), .wrap_clr(wclr),
    .count(c7), .out(o7), .wrap(w7), .wraps(ws7),
    .load_err(e7)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r, i, d, l;
    logic [3:0] lv;
    logic       c;
    logic [3:0] ec;
    logic       eo, ew;
    logic [7:0] ews;
    logic       ee;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    input logic r, i, d, l, input int lv, input logic c,
    input int ec, input logic eo, ew, input int ews,
    input logic ee);
    vec_t v;
    v.r = r; v.i = i; v.d = d; v.l = l;
    v.lv = 4'(lv); v.c = c;
    v.ec = 4'(ec); v.eo = eo; v.ew = ew;
    v.ews = 8'(ews); v.ee = ee;
    tbl.push_back(v);
  endfunction

  initial begin
    // reset state, both directions
    add(0,0,1,0, 0,0,  0,0,0,0,0);
    add(0,0,0,0, 0,0,  0,1,0,0,0);
    // up count 1..9, then wrap to 0
    for (int k = 1; k <= 9; k++)
      add(1,1,1,0, 0,0, k,(k == 9),0,0,0);
    add(1,1,1,0, 0,0,  0,0,1,1,0);
    add(1,0,1,0, 0,0,  0,0,0,1,0);
    // load 3, count down through 0 to 9
    add(1,0,0,1, 3,0,  3,0,0,1,0);
    add(1,1,0,0, 0,0,  2,0,0,1,0);
    add(1,1,0,0, 0,0,  1,0,0,1,0);
    add(1,1,0,0, 0,0,  0,1,0,1,0);
    add(1,1,0,0, 0,0,  9,0,1,2,0);
    add(1,0,0,0, 0,0,  9,0,0,2,0);
    add(1,0,1,0, 0,0,  9,1,0,2,0);
    add(1,0,1,0, 0,1,  9,1,0,0,0);
    // loads: out of range, with in, boundary
    add(1,0,1,1,12,0,  0,0,0,0,1);
    add(1,0,1,0, 0,0,  0,0,0,0,0);
    add(1,1,1,1, 5,0,  5,0,0,0,0);
    add(1,1,1,1, 9,0,  9,1,0,0,0);
    add(1,1,1,1, 9,0,  9,1,0,0,0);
    add(1,0,1,1,10,0,  0,0,0,0,1);
    add(1,1,1,1,15,0,  0,0,0,0,1);
    add(1,0,1,0, 0,0,  0,0,0,0,0);
    add(1,1,0,1, 0,0,  0,1,0,0,0);
    // reset at terminal value with in=1
    add(1,0,1,1, 9,0,  9,1,0,0,0);
    add(0,1,1,0, 0,0,  0,0,0,0,0);
    add(1,1,1,0, 0,0,  1,0,0,0,0);
    add(1,0,1,1, 9,0,  9,1,0,0,0);
    add(0,1,1,1, 5,1,  0,0,0,0,0);
    add(1,1,0,0, 0,0,  9,0,1,1,0);

    foreach (tbl[n]) begin
      rst = tbl[n].r; in = tbl[n].i; dir = tbl[n].d;
      load = tbl[n].l; lva = tbl[n].lv; wclr = tbl[n].c;
      step();
      chk($sformatf("v%0d count", n), ca, tbl[n].ec);
      chk($sformatf("v%0d out", n), oa, tbl[n].eo);
      chk($sformatf("v%0d wrap", n), wa, tbl[n].ew);
      chk($sformatf("v%0d wraps", n), wsa, tbl[n].ews);
      chk($sformatf("v%0d lerr", n), ea, tbl[n].ee);
    end

    // saturating 2-bit wrap total
    rst = 0; in = 0; load = 0; wclr = 0; dir = 1;
    step();
    rst = 1;
    for (int k = 1; k <= 5; k++) begin
      load = 1; lva = 9; in = 0;
      step();
      load = 0; in = 1;
      step();
      chk($sformatf("sat%0d wrap", k), wb, 1);
      chk($sformatf("sat%0d cnt", k), cb, 0);
      chk($sformatf("sat%0d wrapsB", k), wsb, (k > 3) ? 3 : k);
      chk($sformatf("sat%0d wrapsA", k), wsa, k);
    end
    in = 0;
    step();
    chk("sat hold", wsb, 3);
    load = 1; lva = 9;
    step();
    load = 0; in = 1; wclr = 1;
    step();
    chk("clr+wrap B", wsb, 1);
    chk("clr+wrap A", wsa, 1);
    in = 0;
    step();
    chk("clr only", wsb, 0);
    chk("wrap low", wb, 0);
    wclr = 0;

    // power-of-two and odd modulus wraps, both directions
    rst = 0;
    step();
    rst = 1; load = 1; lva = 0; lv16 = 15; lv7 = 6;
    step();
    chk("m16 load", c16, 15);
    chk("m16 out", o16, 1);
    chk("m7 load", c7, 6);
    chk("m7 out", o7, 1);
    load = 0; in = 1; dir = 1;
    step();
    chk("m16 up cnt", c16, 0);
    chk("m16 up wrap", w16, 1);
    chk("m16 wraps", ws16, 1);
    chk("m7 up cnt", c7, 0);
    chk("m7 up wrap", w7, 1);
    dir = 0;
    step();
    chk("m16 dn cnt", c16, 15);
    chk("m16 dn wrap", w16, 1);
    chk("m7 dn cnt", c7, 6);
    chk("m7 dn wrap", w7, 1);
    chk("m7 wraps", ws7, 2);
    load = 1; lv7 = 7; in = 0;
    step();
    chk("m7 lerr", e7, 1);
    chk("m7 lerr cnt", c7, 0);
    chk("m16 no lerr", e16, 0);
    load = 0;
    step();
    chk("m7 lerr end", e7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
